// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXTEND  = 8'hE0;
  localparam logic [7:0]  PS2_RELEASE = 8'hF0;
  localparam int unsigned ENTRY_W     = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // One queued key event: prefix flags plus the scan code.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_entry_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises the raw PS/2 lines and debounces the PS/2 clock.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_filt,
  output logic fall_edge,
  output logic data_sync
);

  logic [1:0]            clk_meta;
  logic [1:0]            data_meta;
  logic [FILTER_LEN-1:0] samples;

  // Two-flop synchronisers, sample history and the filtered clock level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
      samples   <= '1;
      clk_filt  <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      clk_meta  <= {clk_meta[0], ps2_clk};
      data_meta <= {data_meta[0], ps2_data};
      samples   <= {samples[FILTER_LEN-2:0], clk_meta[1]};
      fall_edge <= 1'b0;
      if (&samples) begin
        clk_filt <= 1'b1;
      end else if (~|samples) begin
        clk_filt  <= 1'b0;
        fall_edge <= clk_filt;
      end
    end
  end

  assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: frames bytes, decodes E0/F0 prefixes, queues key events.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  input  logic       Rd_En,
  output logic [7:0] Key_Code,
  output logic       Key_Release,
  output logic       Key_Extended,
  output logic       Key_Valid,
  output logic       Fifo_Full,
  output logic       Parity_Err,
  output logic       Frame_Err,
  output logic       Overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic       clk_filt;
  logic       fall_edge;
  logic       data_sync;
  logic       edge_ok;

  ps2_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic [TW-1:0] tcnt;
  logic       byte_ok;

  logic       ext;
  logic       rel;
  logic       push_q;
  key_entry_t push_data;

  key_entry_t mem [FIFO_DEPTH];
  key_entry_t head;
  key_entry_t head_n;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_n;
  logic [PW-1:0] rd_n;
  logic       pop;
  logic       do_wr;
  logic       full_n;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk       (Clk),
    .rst       (Reset),
    .ps2_clk   (PS2_Clk),
    .ps2_data  (PS2_Data),
    .clk_filt  (clk_filt),
    .fall_edge (fall_edge),
    .data_sync (data_sync)
  );

  // The strobe is only meaningful while the filtered clock is low.
  assign edge_ok = fall_edge & ~clk_filt;

  // Frame FSM with inter-edge timeout; error and byte_ok outputs are pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      byte_ok    <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      byte_ok    <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
      if (state == IDLE || edge_ok) tcnt <= '0;
      else                          tcnt <= tcnt + TW'(1);
      if (edge_ok) begin
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              Frame_Err <= 1'b1;
            end
          end
          DATA: begin
            shreg[bit_cnt] <= data_sync;
            if (bit_cnt == 3'd7) state <= PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
            par_bit <= data_sync;
            state   <= STOP;
          end
          default: begin
            if (!data_sync)              Frame_Err  <= 1'b1;
            else if (^shreg ^ par_bit)   byte_ok    <= 1'b1;
            else                         Parity_Err <= 1'b1;
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        Frame_Err <= 1'b1;
      end
    end
  end

  // Prefix decode: E0/F0 set flags, other bytes become a push request.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ext       <= 1'b0;
      rel       <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      push_q <= 1'b0;
      if (Parity_Err || Frame_Err) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == PS2_EXTEND) begin
          ext <= 1'b1;
        end else if (shreg == PS2_RELEASE) begin
          rel <= 1'b1;
        end else begin
          push_q    <= 1'b1;
          push_data <= '{ext: ext, rel: rel, code: shreg};
          ext       <= 1'b0;
          rel       <= 1'b0;
        end
      end
    end
  end

  // Next pointers and the next head entry, bypassing a write into an emptying queue.
  always_comb begin
    pop    = Rd_En & Key_Valid;
    do_wr  = push_q & (~Fifo_Full | pop);
    rd_n   = rd_ptr + PW'(pop);
    wr_n   = wr_ptr + PW'(do_wr);
    full_n = (wr_n[AW-1:0] == rd_n[AW-1:0]) && (wr_n[AW] != rd_n[AW]);
    head_n = mem[rd_n[AW-1:0]];
    if (do_wr && wr_ptr[AW-1:0] == rd_n[AW-1:0]) head_n = push_data;
  end

  // FIFO storage.
  always_ff @(posedge Clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // FIFO pointers, registered status flags and head entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head      <= '0;
      Key_Valid <= 1'b0;
      Fifo_Full <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_n;
      rd_ptr    <= rd_n;
      head      <= head_n;
      Key_Valid <= (wr_n != rd_n);
      Fifo_Full <= full_n;
      Overflow  <= push_q & Fifo_Full & ~pop;
    end
  end

  assign Key_Code     = head.code;
  assign Key_Release  = head.rel;
  assign Key_Extended = head.ext;

endmodule
